// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 control block: register numbers, exception codes,
// Status/Cause field positions and reset values.
package cp0_pkg;

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;
  localparam logic [4:0] RegPrid     = 5'd15;
  localparam logic [4:0] RegConfig   = 5'd16;

  typedef enum logic [4:0] {
    ExcInt  = 5'd0,
    ExcAdel = 5'd4,
    ExcAdes = 5'd5,
    ExcSys  = 5'd8,
    ExcBp   = 5'd9,
    ExcRi   = 5'd10,
    ExcOv   = 5'd12
  } exc_code_e;

  localparam int unsigned StatusIe    = 0;
  localparam int unsigned StatusExl   = 1;
  localparam int unsigned StatusImLo  = 8;
  localparam int unsigned StatusBev   = 22;
  localparam int unsigned CauseExcLo  = 2;
  localparam int unsigned CauseIpLo   = 8;
  localparam int unsigned CauseTi     = 30;
  localparam int unsigned CauseBd     = 31;

  localparam logic [31:0] StatusRst = 32'h0040_0000;
  localparam logic [31:0] ConfigRst = 32'h0000_8000;

endpackage

// File: rtl/cp0_timer.sv
// Count register with prescaler, plus Compare/TI when CP0_TIMER_EN is defined.
// Without CP0_TIMER_EN only Count runs; Compare and TI read as zero.
import cp0_pkg::*;

module cp0_timer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             count_we_i,
  input  logic             compare_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] compare_o,
  output logic             ti_o
);

  localparam int unsigned PresW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PresW-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             roll;

  assign roll = (presc_q == PresW'(COUNT_DIV - 1));

  // A Count load restarts the prescaler and overrides the increment.
  always_comb begin
    presc_d = roll ? '0 : presc_q + PresW'(1);
    count_d = roll ? count_q + WIDTH'(1) : count_q;
    if (count_we_i) begin
      presc_d = '0;
      count_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

`ifdef CP0_TIMER_EN
  logic [WIDTH-1:0] compare_q, compare_d;
  logic             ti_q, ti_d;

  // Writing Compare acknowledges the timer and beats a same-cycle match.
  always_comb begin
    compare_d = compare_we_i ? wdata_i : compare_q;
    ti_d      = ti_q | (roll && (count_q == compare_q));
    if (compare_we_i) ti_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign compare_o = compare_q;
  assign ti_o      = ti_q;
`else
  logic unused_compare_we;
  assign unused_compare_we = compare_we_i;
  assign compare_o         = '0;
  assign ti_o              = 1'b0;
`endif

endmodule

// File: rtl/cp0_ctrl.sv
// MIPS CP0 register set with exception entry/ERET, hardware interrupts and Count timer.
// Compare/TI timer interrupt is built only when CP0_TIMER_EN is defined.
import cp0_pkg::*;

module cp0_ctrl #(
  parameter int unsigned     WIDTH     = 32,
  parameter int unsigned     HW_IRQ_N  = 6,
  parameter int unsigned     COUNT_DIV = 2,
  parameter logic [WIDTH-1:0] PRID_VAL = WIDTH'(32'h0000_4220)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                mtc0_we_i,
  input  logic [4:0]          mtc0_addr_i,
  input  logic [WIDTH-1:0]    mtc0_wdata_i,
  input  logic [4:0]          raddr_i,
  output logic [WIDTH-1:0]    rdata_o,
  input  logic [HW_IRQ_N-1:0] hw_int_i,
  input  logic                exc_valid_i,
  input  logic [4:0]          exc_code_i,
  input  logic [WIDTH-1:0]    exc_pc_i,
  input  logic                exc_bd_i,
  input  logic                exc_bad_we_i,
  input  logic [WIDTH-1:0]    exc_badvaddr_i,
  input  logic                eret_i,
  output logic [WIDTH-1:0]    epc_o,
  output logic [WIDTH-1:0]    status_o,
  output logic [WIDTH-1:0]    cause_o,
  output logic                exl_o,
  output logic                int_req_o
);

  logic [WIDTH-1:0] badvaddr_q, badvaddr_d, epc_q, epc_d;
  logic [7:0]       im_q, im_d;
  logic             exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [4:0]       exc_code_q, exc_code_d;
  logic [1:0]       ip_sw_q, ip_sw_d;
  logic [5:0]       ip_hw_q, ip_hw_d;

  logic             mtc0_en, count_we, compare_we, ti;
  logic [WIDTH-1:0] count, compare;
  logic [7:0]       cause_ip;
  logic [31:0]      status_w, cause_w;

  // Exception and ERET commits swallow any same-cycle MTC0.
  assign mtc0_en    = mtc0_we_i & ~exc_valid_i & ~eret_i;
  assign count_we   = mtc0_en && (mtc0_addr_i == RegCount);
  assign compare_we = mtc0_en && (mtc0_addr_i == RegCompare);

  cp0_timer #(
    .WIDTH     (WIDTH),
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .count_we_i   (count_we),
    .compare_we_i (compare_we),
    .wdata_i      (mtc0_wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  always_comb begin
    badvaddr_d = badvaddr_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = 6'(hw_int_i);
    if (exc_valid_i) begin
      // Nested exceptions keep the original return point.
      if (!exl_q) begin
        epc_d = exc_bd_i ? exc_pc_i - WIDTH'(4) : exc_pc_i;
        bd_d  = exc_bd_i;
      end
      exc_code_d = exc_code_i;
      exl_d      = 1'b1;
      if (exc_bad_we_i) badvaddr_d = exc_badvaddr_i;
    end else if (eret_i) begin
      exl_d = 1'b0;
    end else if (mtc0_we_i) begin
      case (mtc0_addr_i)
        RegBadVAddr: badvaddr_d = mtc0_wdata_i;
        RegEpc:      epc_d      = mtc0_wdata_i;
        RegStatus: begin
          im_d  = mtc0_wdata_i[15:8];
          exl_d = mtc0_wdata_i[1];
          ie_d  = mtc0_wdata_i[0];
        end
        RegCause:    ip_sw_d    = mtc0_wdata_i[9:8];
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      badvaddr_q <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
    end
  end

  assign cause_ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};

  always_comb begin
    status_w                       = StatusRst;
    status_w[StatusImLo +: 8]      = im_q;
    status_w[StatusExl]            = exl_q;
    status_w[StatusIe]             = ie_q;
    cause_w                        = '0;
    cause_w[CauseBd]               = bd_q;
    cause_w[CauseTi]               = ti;
    cause_w[CauseIpLo +: 8]        = cause_ip;
    cause_w[CauseExcLo +: 5]       = exc_code_q;
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      RegBadVAddr: rdata_o = badvaddr_q;
      RegCount:    rdata_o = count;
      RegCompare:  rdata_o = compare;
      RegStatus:   rdata_o = WIDTH'(status_w);
      RegCause:    rdata_o = WIDTH'(cause_w);
      RegEpc:      rdata_o = epc_q;
      RegPrid:     rdata_o = PRID_VAL;
      RegConfig:   rdata_o = WIDTH'(ConfigRst);
      default:     rdata_o = '0;
    endcase
  end

  assign epc_o     = epc_q;
  assign status_o  = WIDTH'(status_w);
  assign cause_o   = WIDTH'(cause_w);
  assign exl_o     = exl_q;
  assign int_req_o = ie_q & ~exl_q & (|(cause_ip & im_q));

endmodule
